// File: rtl/multicycle_control.sv
// Purpose : main control FSM for the multi-cycle MIPS datapath (shared ALU, unified memory, register file).
// Latency : 3-5 cycles per instruction (2 for an illegal opcode) plus one cycle per mem_ready=0 cycle in a memory state.
// Backpress: memory strobes are held and the FSM stalls in FETCH/MEM_RD/MEM_WR until mem_ready; mem_ready is ignored elsewhere.
//
// Ports:
//   clk, rst          - single rising-edge clock, synchronous active-high reset
//   op[5:0]           - opcode from the instruction register
//   mem_ready         - memory completes the current access this cycle
//   mem_read/mem_write/iord          - memory strobes and address select (0 = PC, 1 = ALUOut)
//   ir_write/pc_write/pc_write_cond/branch_ne/pc_source[1:0] - IR and PC update controls
//   alu_src_a/alu_src_b[1:0]/zero_ext/alu_op[2:0]            - ALU operand and operation selects
//   reg_write/reg_dst/mem_to_reg     - register-file write controls
//   illegal_op        - one-cycle pulse in DECODE on an undefined opcode
//   state[3:0]        - current state (reads 0 while rst is high)

module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    // ALU operand B selects
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State encoding is visible on the state port, so the values are fixed.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_ALU_WB_R = 4'd7,
        S_BRANCH   = 4'd8,
        S_EXEC_I   = 4'd9,
        S_ALU_WB_I = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // While rst is high the state register may still hold a mid-instruction
    // state for this cycle; the port reads 0 so nothing downstream sees it.
    assign state = rst ? 4'd0 : state_q;

    // Next-state and output decode. Every output is gated by rst so that no
    // strobe (in particular a memory write) escapes in the reset cycle.
    always_comb begin
        state_d       = S_FETCH;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        zero_ext      = 1'b0;
        alu_op        = ALU_ADD;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    // PC + 4 is computed every fetch cycle; the PC and IR
                    // only commit on the cycle the memory returns data.
                    mem_read  = 1'b1;
                    iord      = 1'b0;
                    alu_src_a = 1'b0;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    pc_source = PCSRC_ALU;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    state_d   = mem_ready ? S_DECODE : S_FETCH;
                end

                S_DECODE: begin
                    // Speculative branch target into ALUOut.
                    alu_src_a = 1'b0;
                    alu_src_b = SRCB_IMMSH;
                    alu_op    = ALU_ADD;
                    case (op)
                        OP_LW, OP_SW:             state_d = S_MEM_ADDR;
                        OP_RTYPE:                 state_d = S_EXEC_R;
                        OP_BEQ, OP_BNE:           state_d = S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
                        OP_J:                     state_d = S_JUMP;
                        default: begin
                            state_d    = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end

                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                    // Only lw and sw reach this state.
                    state_d   = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end

                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
                end

                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b0;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end

                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    state_d   = mem_ready ? S_FETCH : S_MEM_WR;
                end

                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_B;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_ALU_WB_R;
                end

                S_ALU_WB_R: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    mem_to_reg = 1'b0;
                    state_d    = S_FETCH;
                end

                S_BRANCH: begin
                    // Compare A and B; the target computed in DECODE sits in ALUOut.
                    alu_src_a     = 1'b1;
                    alu_src_b     = SRCB_B;
                    alu_op        = ALU_SUB;
                    pc_source     = PCSRC_ALUOUT;
                    pc_write_cond = 1'b1;
                    branch_ne     = (op == OP_BNE);
                    state_d       = S_FETCH;
                end

                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    case (op)
                        OP_ANDI: begin
                            alu_op   = ALU_AND;
                            zero_ext = 1'b1;
                        end
                        OP_ORI: begin
                            alu_op   = ALU_OR;
                            zero_ext = 1'b1;
                        end
                        default: begin
                            alu_op   = ALU_ADD;
                            zero_ext = 1'b0;
                        end
                    endcase
                    state_d = S_ALU_WB_I;
                end

                S_ALU_WB_I: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b0;
                    mem_to_reg = 1'b0;
                    state_d    = S_FETCH;
                end

                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    state_d   = S_FETCH;
                end

                default: begin
                    // Encodings 12-15: all outputs stay 0, recover to FETCH.
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into
// its expected state path (with inserted memory wait cycles), and every cycle's
// state and control outputs are compared against a per-state control table.

module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } ctrl_t;

    // Expected path for the instruction under test
    logic [3:0] exp_st [$];
    logic       exp_mr [$];

    multicycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .zero_ext      (zero_ext),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c.mem_read      = mem_read;
        c.mem_write     = mem_write;
        c.iord          = iord;
        c.ir_write      = ir_write;
        c.pc_write      = pc_write;
        c.pc_write_cond = pc_write_cond;
        c.branch_ne     = branch_ne;
        c.pc_source     = pc_source;
        c.alu_src_a     = alu_src_a;
        c.alu_src_b     = alu_src_b;
        c.zero_ext      = zero_ext;
        c.alu_op        = alu_op;
        c.reg_write     = reg_write;
        c.reg_dst       = reg_dst;
        c.mem_to_reg    = mem_to_reg;
        c.illegal_op    = illegal_op;
        return c;
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return (o == 6'h00) || (o == 6'h23) || (o == 6'h2b) || (o == 6'h04) || (o == 6'h05) ||
               (o == 6'h08) || (o == 6'h0c) || (o == 6'h0d) || (o == 6'h02);
    endfunction

    // Control table: what each state must drive, given op and mem_ready.
    function automatic ctrl_t model_ctrl(input logic [3:0] st, input logic [5:0] o, input logic mr);
        ctrl_t c;
        c = '0;
        case (st)
            4'd0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            4'd1: begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(o); end
            4'd2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3: begin c.mem_read = 1; c.iord = 1; end
            4'd4: begin c.reg_write = 1; c.mem_to_reg = 1; end
            4'd5: begin c.mem_write = 1; c.iord = 1; end
            4'd6: begin c.alu_src_a = 1; c.alu_op = 3'b010; end
            4'd7: begin c.reg_write = 1; c.reg_dst = 1; end
            4'd8: begin
                c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_source = 2'b01;
                c.pc_write_cond = 1; c.branch_ne = (o == 6'h05);
            end
            4'd9: begin
                c.alu_src_a = 1; c.alu_src_b = 2'b10;
                c.alu_op   = (o == 6'h0c) ? 3'b011 : (o == 6'h0d) ? 3'b100 : 3'b000;
                c.zero_ext = (o == 6'h0c) || (o == 6'h0d);
            end
            4'd10: c.reg_write = 1;
            4'd11: begin c.pc_write = 1; c.pc_source = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Drive one cycle's inputs at the falling edge, then settle before sampling.
    task automatic tick(input logic r, input logic [5:0] o, input logic mr);
        @(negedge clk);
        rst       = r;
        op        = o;
        mem_ready = mr;
        #1;
    endtask

    task automatic add_step(input logic [3:0] st, input logic mr);
        exp_st.push_back(st);
        exp_mr.push_back(mr);
    endtask

    // Instruction-level path: fetch (with waits), decode, then the class-specific tail.
    task automatic build_path(input logic [5:0] o, input int fw, input int mw);
        exp_st.delete();
        exp_mr.delete();
        for (int i = 0; i < fw; i++) add_step(4'd0, 1'b0);
        add_step(4'd0, 1'b1);
        add_step(4'd1, 1'($urandom_range(0, 1)));
        case (o)
            6'h23: begin
                add_step(4'd2, 1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) add_step(4'd3, 1'b0);
                add_step(4'd3, 1'b1);
                add_step(4'd4, 1'($urandom_range(0, 1)));
            end
            6'h2b: begin
                add_step(4'd2, 1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) add_step(4'd5, 1'b0);
                add_step(4'd5, 1'b1);
            end
            6'h00: begin
                add_step(4'd6, 1'($urandom_range(0, 1)));
                add_step(4'd7, 1'($urandom_range(0, 1)));
            end
            6'h04, 6'h05: add_step(4'd8, 1'($urandom_range(0, 1)));
            6'h08, 6'h0c, 6'h0d: begin
                add_step(4'd9, 1'($urandom_range(0, 1)));
                add_step(4'd10, 1'($urandom_range(0, 1)));
            end
            6'h02: add_step(4'd11, 1'($urandom_range(0, 1)));
            default: ;
        endcase
    endtask

    // Run one instruction from FETCH and check every cycle plus instruction totals.
    task automatic test_instr(input logic [5:0] o, input int fw, input int mw, input string name);
        int         n_ir;
        int         n_ill;
        logic [5:0] cur_op;
        ctrl_t      want;
        ctrl_t      got;
        n_ir  = 0;
        n_ill = 0;
        build_path(o, fw, mw);
        for (int i = 0; i < exp_st.size(); i++) begin
            // The IR still holds the previous opcode during FETCH.
            cur_op = (exp_st[i] == 4'd0) ? 6'($urandom_range(0, 63)) : o;
            tick(1'b0, cur_op, exp_mr[i]);
            want = model_ctrl(exp_st[i], cur_op, exp_mr[i]);
            got  = dut_ctrl();
            checks++;
            if (state !== exp_st[i]) begin
                errors++;
                $display("FAIL %s state cyc %0d: got %0d want %0d", name, i, state, exp_st[i]);
            end
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s ctrl cyc %0d st %0d: got %h want %h", name, i, exp_st[i], got, want);
            end
            checks++;
            if ((pc_write || ir_write) && (reg_write || mem_write)) begin
                errors++;
                $display("FAIL %s write_overlap cyc %0d: got pc/ir with reg/mem write", name, i);
            end
            n_ir  += int'(ir_write);
            n_ill += int'(illegal_op);
        end
        checks++;
        if (n_ir !== 1) begin
            errors++;
            $display("FAIL %s ir_write_count: got %0d want 1", name, n_ir);
        end
        checks++;
        if (n_ill !== (is_legal(o) ? 0 : 1)) begin
            errors++;
            $display("FAIL %s illegal_count: got %0d want %0d", name, n_ill, is_legal(o) ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            checks++;
            if (state !== 4'd0) begin
                errors++;
                $display("FAIL reset_state cyc %0d: got %0d want 0", i, state);
            end
            checks++;
            if (dut_ctrl() !== ctrl_t'('0)) begin
                errors++;
                $display("FAIL reset_ctrl cyc %0d: got %h want 0", i, dut_ctrl());
            end
        end
    endtask

    task automatic test_rtype();     test_instr(6'h00, 0, 0, "rtype");   endtask
    task automatic test_lw_waits();  test_instr(6'h23, 2, 3, "lw_waits"); endtask
    task automatic test_sw_waits();  test_instr(6'h2b, 1, 2, "sw_waits"); endtask
    task automatic test_jump();      test_instr(6'h02, 0, 0, "jump");    endtask
    task automatic test_illegal();   test_instr(6'h3f, 0, 0, "illegal"); endtask

    task automatic test_branch();
        test_instr(6'h05, 0, 0, "bne");
        test_instr(6'h04, 0, 0, "beq");
    endtask

    task automatic test_imm();
        test_instr(6'h0d, 0, 0, "ori");
        test_instr(6'h0c, 0, 0, "andi");
        test_instr(6'h08, 0, 0, "addi");
    endtask

    // Reset while sw waits in MEM_WR, then a 3-cycle reset from FETCH.
    task automatic test_reset_mid();
        ctrl_t fetch_idle;
        fetch_idle = model_ctrl(4'd0, 6'h2b, 1'b0);
        tick(1'b0, 6'h11, 1'b1);
        tick(1'b0, 6'h2b, 1'b1);
        tick(1'b0, 6'h2b, 1'b0);
        tick(1'b0, 6'h2b, 1'b0);
        checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rmid_reach_memwr: got st %0d mw %0d want st 5 mw 1", state, mem_write);
        end
        tick(1'b1, 6'h2b, 1'b0);
        checks++;
        if (dut_ctrl() !== ctrl_t'('0) || state !== 4'd0) begin
            errors++;
            $display("FAIL rmid_rst_cycle: got ctrl %h st %0d want 0 0", dut_ctrl(), state);
        end
        tick(1'b0, 6'h2b, 1'b0);
        checks++;
        if (state !== 4'd0 || dut_ctrl() !== fetch_idle) begin
            errors++;
            $display("FAIL rmid_after: got st %0d ctrl %h want 0 %h", state, dut_ctrl(), fetch_idle);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            checks++;
            if (dut_ctrl() !== ctrl_t'('0) || state !== 4'd0) begin
                errors++;
                $display("FAIL rmid_hold cyc %0d: got ctrl %h st %0d want 0 0", i, dut_ctrl(), state);
            end
        end
        tick(1'b0, 6'h00, 1'b0);
        checks++;
        if (state !== 4'd0 || dut_ctrl() !== fetch_idle) begin
            errors++;
            $display("FAIL rmid_resume: got st %0d ctrl %h want 0 %h", state, dut_ctrl(), fetch_idle);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        logic [5:0] o;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h02};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 3) o = 6'($urandom_range(0, 63));
            else                          o = ops[$urandom_range(0, 8)];
            test_instr(o, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        rst       = 1'b1;
        op        = 6'h00;
        mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_waits();
        test_branch();
        test_imm();
        test_illegal();
        test_sw_waits();
        test_jump();
        test_reset_mid();
        test_random();
        test_rtype();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. Sequences one shared ALU, one unified instruction/data memory and the register file across 3–5 cycles per instruction. Opcode comes from the instruction register. Memory accesses stall on a `mem_ready` handshake. Replaces the single-cycle opcode decoder when the processor is built in multi-cycle form.

## Interface
Parameters:
- none (state encoding is fixed: 4 bits, values below).

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `op`  in  6  — opcode from the IR. The datapath holds it stable from the cycle after `ir_write` until the next `ir_write`.
- `mem_ready`  in  1  — memory completes the current read/write this cycle.
- `mem_read`, `mem_write`  out  1  — memory strobes, held until `mem_ready`.
- `iord`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  — load the IR.
- `pc_write`  out  1  — unconditional PC load.
- `pc_write_cond`  out  1  — PC load qualified by the ALU zero flag.
- `branch_ne`  out  1  — invert the zero qualification (bne).
- `pc_source`  out  2  — 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  — 0 = PC, 1 = A register.
- `alu_src_b`  out  2  — 00 = B, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2.
- `zero_ext`  out  1  — zero-extend rather than sign-extend the immediate.
- `alu_op`  out  3  — 000 add, 001 sub, 010 funct-decoded, 011 and, 100 or.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each — register-file write controls.
- `illegal_op`  out  1  — one-cycle pulse on an undefined opcode.
- `state`  out  4  — current state, for debug and the bench.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010. All other opcodes are illegal.
- Any output not listed for a state is 0.
- FETCH (0):
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy).
  - Stay in FETCH while `mem_ready`=0; go to DECODE when `mem_ready`=1.
- DECODE (1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=000 (branch target into ALUOut). Next state by `op`:
  - lw/sw → MEM_ADDR
  - R-type → EXEC_R
  - beq/bne → BRANCH
  - addi/andi/ori → EXEC_I
  - j → JUMP
  - illegal → FETCH, with `illegal_op`=1 this cycle.
- MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000. Next: lw → MEM_RD, sw → MEM_WR.
- MEM_RD (3): `mem_read`=1, `iord`=1. Wait for `mem_ready`, then → MEM_WB.
- MEM_WB (4): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next → FETCH.
- MEM_WR (5): `mem_write`=1, `iord`=1. Wait for `mem_ready`, then → FETCH.
- EXEC_R (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010. Next → ALU_WB_R.
- ALU_WB_R (7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next → FETCH.
- BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_source`=01, `pc_write_cond`=1, `branch_ne`=(op==bne). Next → FETCH.
- EXEC_I (9): `alu_src_a`=1, `alu_src_b`=10.
  - `alu_op`: addi 000, andi 011, ori 100.
  - `zero_ext`=1 for andi/ori.
  - Next → ALU_WB_I.
- ALU_WB_I (10): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next → FETCH.
- JUMP (11): `pc_write`=1, `pc_source`=10. Next → FETCH.
- Unused encodings 12–15 → FETCH on the next edge, with all outputs 0 while in them.

## Timing
- Reset:
  - `rst`=1 at an edge loads `state`=FETCH.
  - While `rst`=1, every output is forced to 0, including `mem_read`; `state` reads 0.
  - FETCH outputs appear in the first cycle after `rst` deasserts.
- Reset mid-instruction (any state, including memory-wait states) abandons the instruction. No write strobe is asserted in the `rst` cycle.
- Latency with zero wait states (`mem_ready` tied 1):
  - lw: 5 cycles
  - R-type, addi/andi/ori, sw: 4 cycles
  - beq/bne, j: 3 cycles
  - illegal: 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_ready` is ignored in all other states.
- `pc_write` and `ir_write` are never asserted in the same cycle as `reg_write` or `mem_write`.
- `op` is sampled only in DECODE, MEM_ADDR, BRANCH and EXEC_I.

## Test plan
- Reset, `mem_ready`=1, `op`=000000 → `state` sequence 0,1,6,7,0. `ir_write`=`pc_write`=1 only in cycle 1. `alu_op`=010 in state 6. `reg_write`=`reg_dst`=1 in state 7.
- `op`=100011 with `mem_ready` low for 2 cycles in FETCH and 3 in MEM_RD → total 10 cycles. `ir_write` pulses once, in the cycle `mem_ready` rises. `mem_read`=1 throughout both waits. `mem_to_reg`=1 in state 4.
- `op`=000101 → states 0,1,8,0. In state 8: `branch_ne`=1, `pc_write_cond`=1, `alu_op`=001. Repeat with 000100 → `branch_ne`=0.
- Cover addi, andi, ori:
  - `op`=001101 → EXEC_I outputs `alu_op`=100, `zero_ext`=1.
  - `op`=001000 → `alu_op`=000, `zero_ext`=0.
- `op`=111111 → `illegal_op`=1 for exactly one cycle in DECODE, then `state`=0, with no register or memory write.
- Assert `rst` in MEM_WR while `mem_ready`=0 → all outputs 0 that cycle, `state`=0 next cycle. Assert `rst` again for 3 cycles → outputs stay 0, and FETCH resumes one cycle after release.
